// File: rtl/tritone_tpu_pkg.sv
// Shared types and constants for the ternary TPU datapath: trit encodings
// and the weight-loader state enum.
package tritone_tpu_pkg;

    localparam logic [1:0] TRIT_NEG     = 2'b00;
    localparam logic [1:0] TRIT_ZERO    = 2'b01;
    localparam logic [1:0] TRIT_POS     = 2'b10;
    localparam logic [1:0] TRIT_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        WL_IDLE = 2'd0,
        WL_FILL = 2'd1,
        WL_LOAD = 2'd2,
        WL_DONE = 2'd3
    } wl_state_e;

    // The only illegal code is forced to zero so it cannot bias a dot product.
    function automatic logic [1:0] trit_clean(input logic [1:0] t);
        return (t == TRIT_ILLEGAL) ? TRIT_ZERO : t;
    endfunction

endpackage

// File: rtl/ternary_weight_loader_if.sv
// Host-side control, beat stream and array weight-port signals of the loader.
// Stream handshake: a beat transfers on a rising clk edge where s_valid and s_ready are both high.
interface ternary_weight_loader_if #(
    parameter int ARRAY_SIZE = 64,
    parameter int WORD_BITS  = 32
);
    localparam int ROW_W = $clog2(ARRAY_SIZE);

    logic                        start;
    logic                        abort;
    logic [ROW_W-1:0]            first_row;
    logic [ROW_W:0]              row_count;
    logic                        s_valid;
    logic                        s_ready;
    logic [WORD_BITS-1:0]        s_data;
    logic                        weight_load;
    logic [ROW_W-1:0]            weight_row;
    logic [ARRAY_SIZE-1:0][1:0]  weights_in;
    logic                        busy;
    logic                        done;
    logic                        code_err;

    modport master (
        output start, abort, first_row, row_count, s_valid, s_data,
        input  s_ready, weight_load, weight_row, weights_in, busy, done, code_err
    );

    modport slave (
        input  start, abort, first_row, row_count, s_valid, s_data,
        output s_ready, weight_load, weight_row, weights_in, busy, done, code_err
    );

endinterface

// File: rtl/ternary_trit_sanitize.sv
// Per-beat trit cleaner: maps the illegal code to zero and flags its presence.
module ternary_trit_sanitize
    import tritone_tpu_pkg::*;
#(
    parameter int WORD_BITS = 32
) (
    input  logic [WORD_BITS-1:0] i_data,
    output logic [WORD_BITS-1:0] o_data,
    output logic                 o_illegal
);
    localparam int TPB = WORD_BITS / 2;

    always_comb begin
        o_data    = '0;
        o_illegal = 1'b0;
        for (int i = 0; i < TPB; i++) begin
            o_data[2*i +: 2] = trit_clean(i_data[2*i +: 2]);
            if (i_data[2*i +: 2] == TRIT_ILLEGAL) begin
                o_illegal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ternary_weight_loader.sv
// Assembles full array rows from a packed-trit beat stream and writes a
// contiguous, wrapping range of rows into the systolic array.
module ternary_weight_loader
    import tritone_tpu_pkg::*;
#(
    parameter int ARRAY_SIZE = 64,
    parameter int WORD_BITS  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ternary_weight_loader_if.slave wl,
    output wl_state_e              o_dbg_state
);
    localparam int TPB    = WORD_BITS / 2;
    localparam int BPR    = (2 * ARRAY_SIZE) / WORD_BITS;
    localparam int ROW_W  = $clog2(ARRAY_SIZE);
    localparam int BEAT_W = (BPR > 1) ? $clog2(BPR) : 1;

    wl_state_e                  r_state;
    wl_state_e                  w_next;
    logic [ROW_W-1:0]           r_row_ptr;
    logic [ROW_W:0]             r_rows_left;
    logic [BEAT_W-1:0]          r_beat_idx;
    logic [ARRAY_SIZE-1:0][1:0] r_row_buf;
    logic                       r_code_err;

    logic [WORD_BITS-1:0]       w_clean;
    logic                       w_illegal;
    logic                       w_last_beat;
    logic [ROW_W-1:0]           w_row_next;

    ternary_trit_sanitize #(.WORD_BITS(WORD_BITS)) u_sanitize (
        .i_data    (wl.s_data),
        .o_data    (w_clean),
        .o_illegal (w_illegal)
    );

    assign w_last_beat = (r_beat_idx == BEAT_W'(BPR - 1));
    assign w_row_next  = (r_row_ptr == ROW_W'(ARRAY_SIZE - 1)) ? '0 : r_row_ptr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WL_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            WL_IDLE: begin
                if (wl.start) begin
                    w_next = (wl.row_count != '0) ? WL_FILL : WL_DONE;
                end
            end
            WL_FILL: begin
                if (wl.s_valid && w_last_beat) begin
                    w_next = WL_LOAD;
                end
            end
            WL_LOAD: begin
                w_next = (r_rows_left == (ROW_W+1)'(1)) ? WL_DONE : WL_FILL;
            end
            WL_DONE: begin
                w_next = WL_IDLE;
            end
            default: begin
                w_next = WL_IDLE;
            end
        endcase
        if (wl.abort) begin
            w_next = WL_IDLE;
        end
    end

    // Abort freezes everything except the beat counter, so a half-filled row is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_ptr   <= '0;
            r_rows_left <= '0;
            r_beat_idx  <= '0;
            r_row_buf   <= {ARRAY_SIZE{TRIT_ZERO}};
            r_code_err  <= 1'b0;
        end else if (wl.abort) begin
            r_beat_idx <= '0;
        end else begin
            case (r_state)
                WL_IDLE: begin
                    if (wl.start) begin
                        r_code_err <= 1'b0;
                        if (wl.row_count != '0) begin
                            r_row_ptr   <= wl.first_row;
                            r_rows_left <= wl.row_count;
                            r_beat_idx  <= '0;
                        end
                    end
                end
                WL_FILL: begin
                    if (wl.s_valid) begin
                        r_row_buf[int'(r_beat_idx) * TPB +: TPB] <= w_clean;
                        r_beat_idx <= w_last_beat ? '0 : r_beat_idx + 1'b1;
                        if (w_illegal) begin
                            r_code_err <= 1'b1;
                        end
                    end
                end
                WL_LOAD: begin
                    r_row_ptr   <= w_row_next;
                    r_rows_left <= r_rows_left - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign wl.s_ready     = (r_state == WL_FILL);
    assign wl.weight_load = (r_state == WL_LOAD);
    assign wl.weight_row  = r_row_ptr;
    assign wl.weights_in  = r_row_buf;
    assign wl.busy        = (r_state != WL_IDLE);
    assign wl.done        = (r_state == WL_DONE);
    assign wl.code_err    = r_code_err;
    assign o_dbg_state    = r_state;

endmodule

// File: doc/ternary_weight_loader.md
# ternary_weight_loader

Streams packed ternary weights from a valid/ready word source and drives the weight-load port of the 64×64 hierarchical ternary systolic array, one full row per `weight_load` pulse. It sits directly upstream of the array's `weight_load` / `weight_row` / `weights_in` inputs. It assembles `ARRAY_SIZE` trits per row from `WORD_BITS`-wide beats, sanitizes illegal trit codes, and sequences a contiguous, wrapping range of rows under a start/done handshake.

## Interface
- `ARRAY_SIZE`, 64, trits per row and number of array rows.
- `WORD_BITS`, 32, stream beat width. Must divide `2*ARRAY_SIZE`. Derived: `TRITS_PER_BEAT = WORD_BITS/2`, `BEATS_PER_ROW = 2*ARRAY_SIZE/WORD_BITS` (4 at defaults).

Ports:
- `clk`, in, 1, clock.
- `rst_n`, in, 1, reset, asynchronous, active-low.
- `start`, in, 1, begin a load sequence; sampled only in IDLE.
- `abort`, in, 1, cancel the sequence from any state.
- `first_row`, in, `$clog2(ARRAY_SIZE)`, first global row to load; latched on start.
- `row_count`, in, `$clog2(ARRAY_SIZE)+1`, rows to load (0..64); latched on start.
- `s_valid`, in, 1, stream beat valid.
- `s_ready`, out, 1, loader accepts a beat.
- `s_data`, in, `WORD_BITS`, packed trits. Bits [1:0] hold the lowest column of the beat.
- `weight_load`, out, 1, one-cycle row write strobe to the array.
- `weight_row`, out, `$clog2(ARRAY_SIZE)`, global row index for the strobe.
- `weights_in`, out, `[ARRAY_SIZE-1:0][1:0]`, row data. Encoding: 00 = −1, 01 = 0, 10 = +1.
- `busy`, out, 1, high in every state except IDLE.
- `done`, out, 1, one-cycle pulse when the sequence completes.
- `code_err`, out, 1, sticky flag: an illegal code 2'b11 was seen since the last accepted start.

## Operation
- FSM states: IDLE, FILL, LOAD, DONE.
- **IDLE**
  - `start=1` with `row_count≠0`: latch `first_row` into `row_ptr` and `row_count` into `rows_left`, clear `beat_idx` and `code_err`, go to FILL.
  - `start=1` with `row_count=0`: clear `code_err`, go to DONE.
- **FILL**
  - `s_ready=1`.
  - Each handshake (`s_valid & s_ready`) writes beat `beat_idx` into row buffer columns `[beat_idx*TRITS_PER_BEAT +: TRITS_PER_BEAT]`, then increments `beat_idx`.
  - Acceptance of beat `BEATS_PER_ROW-1` → LOAD, and `beat_idx` returns to 0.
- **LOAD**
  - `s_ready=0`; `weight_load=1`, `weight_row=row_ptr`, `weights_in`=row buffer.
  - `row_ptr` advances modulo `ARRAY_SIZE`, so 63 wraps to 0.
  - `rows_left` decrements. If it becomes 0, go to DONE; otherwise go to FILL.
- **DONE**: `done=1` for one cycle, then IDLE.
- Sanitizing: each incoming trit equal to 2'b11 is stored as 2'b01 (zero) and sets `code_err`. `code_err` holds until the next accepted start.
- `start` outside IDLE is ignored.
- `abort` has priority over all transitions:
  - next state IDLE, `beat_idx` cleared, no `weight_load`, no `done`.
  - A beat handshaking in the same cycle is discarded.
  - Rows already written to the array stay written.
- `weights_in` is registered and changes only on beat acceptance. It is meaningful only while `weight_load=1`.

## Timing
- Reset values: state IDLE, `s_ready=0`, `weight_load=0`, `weight_row=0`, `weights_in` all 2'b01, `busy=0`, `done=0`, `code_err=0`.
- All outputs are registered or decoded from state; there is no combinational path from `s_valid` to `s_ready`.
- Sequence from `start` sampled at cycle T:
  - `busy=1` and `s_ready=1` from T+1.
  - With beats arriving back-to-back, beats accepted at T+1..T+4, `weight_load` at T+5, next beat at T+6.
- Throughput: `BEATS_PER_ROW+1` cycles per row; a full 64-row load takes 320 cycles plus 1 cycle for DONE.
- `done` occurs one cycle after the final `weight_load`; `busy` falls the cycle after `done`.
- `row_count=0`: `done` at T+1, IDLE at T+2, no `weight_load`.
- Stalls: `s_valid=0` holds FILL indefinitely with `beat_idx` unchanged.

## Structure
- Shared package `tritone_tpu_pkg`:
  - trit constants `TRIT_NEG=2'b00`, `TRIT_ZERO=2'b01`, `TRIT_POS=2'b10`, `TRIT_ILLEGAL=2'b11`;
  - loader state enum `wl_state_e`.
- One sub-module is natural: `ternary_trit_sanitize`, combinational per-beat, mapping 11→01 and producing an any-illegal flag.
- Counters and row buffer live in the top module.

## Test plan
- **Full load.** Reset, then `start` with `first_row=0`, `row_count=64`, beats streamed back-to-back, row r filled with +1.
  - Expect 64 strobes, `weight_row` 0..63, each `weights_in` all 2'b10.
  - Expect strobes 5 cycles apart, `done` 1 cycle after the last strobe, `code_err=0`.
- **Wrap.** `first_row=62`, `row_count=3`.
  - Expect `weight_row` sequence 62, 63, 0, then `done`.
- **Stalls and sanitizing.** `s_valid` toggling randomly; beat 2 of row 5 contains 0xFFFFFFFF.
  - Expect row 5 columns 32..47 equal to 2'b01, `code_err=1`, and the strobe only after the 4th accepted beat.
- **Abort.** `abort` asserted in row 3 after 2 beats.
  - Expect IDLE next cycle, no further strobes, no `done`.
  - A following `start` with `first_row=3`, `row_count=1` loads cleanly with `beat_idx` starting at 0.
- **Zero rows and ignored start.** `start` with `row_count=0` → `done` at T+1, no strobe. `start` pulsed while `busy` → ignored, single `done`.
- **Async reset mid-FILL.** All outputs take their reset values immediately; no `weight_load` after reset release.
